// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-access stage: access-size encodings and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_lsu_pkg;

    // funct3 access-size encodings; stores use only the low two bits
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Low-bit width classes shared by loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load lane extract + extension.
// Latency: purely combinational.
// Backpressure: none; the results follow the inputs.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_dat_i,
    input  logic [31:0] rd_dat_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_dat_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_unsigned;

    // Lane selection and extension; unaligned low bits are simply ignored for half/word
    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = st_dat_i;
        ld_dat_o    = rd_dat_i;
        byte_sel    = rd_dat_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? rd_dat_i[31:16] : rd_dat_i[15:0];
        is_unsigned = size_i[2];
        case (size_i[1:0])
            SZ_BYTE: begin
                be_o     = 4'b0001 << addr_lo_i;
                wdata_o  = {4{st_dat_i[7:0]}};
                ld_dat_o = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_o     = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o  = {2{st_dat_i[15:0]}};
                ld_dat_o = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be_o     = 4'b1111;
                wdata_o  = st_dat_i;
                ld_dat_o = rd_dat_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: runs loads/stores on a req/ack data bus and registers the MEM/WB result.
// Latency: 1 cycle for ALU ops and zero-wait accesses; +1 per memory wait state, bus error after MAX_WAIT.
// Backpressure: stall_o holds upstream while an access is outstanding. Optional: MISALIGN_TRAP_EN.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_mem,
    input  logic              registerWriteEnable_i,
    input  logic              dataWriteEnable_i,
    input  logic              regSelect_i,
    input  logic [2:0]        memSize_i,
    input  logic [DATA_W-1:0] aluOut_i,
    input  logic [DATA_W-1:0] dataB_i,
    input  logic [4:0]        rd_i,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_o,
    output logic [ADDR_W-1:0] pc_wb,
    output logic              registerWriteEnable_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] wbData_o,
    output logic              busError_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [4:0]        rd_q, rd_d;
    logic              wbe_q, wbe_d;
    logic [DATA_W-1:0] wbd_q, wbd_d;
    logic              berr_q, berr_d;

    logic        is_mem, is_load, misalign;
    logic        req_c, stall_c, complete, timeout, trap, pass;
    logic [3:0]  be_c;
    logic [31:0] ld_dat;

    assign is_mem  = dataWriteEnable_i | regSelect_i;
    assign is_load = regSelect_i & ~dataWriteEnable_i;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((memSize_i[1:0] == SZ_HALF) & aluOut_i[0]) |
                      ((memSize_i[1:0] == MEM_W[1:0]) & (aluOut_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    lsu_lane_align u_align (
        .size_i    (memSize_i),
        .addr_lo_i (aluOut_i[1:0]),
        .st_dat_i  (dataB_i),
        .rd_dat_i  (dmem_rdata),
        .be_o      (be_c),
        .wdata_o   (dmem_wdata),
        .ld_dat_o  (ld_dat)
    );

    // Bus drives come straight from the held upstream inputs; reset kills the request at once
    assign dmem_req  = req_c & ~rst;
    assign dmem_we   = dmem_req & dataWriteEnable_i;
    assign dmem_be   = dmem_req ? be_c : 4'b0000;
    assign dmem_addr = {aluOut_i[ADDR_W-1:2], 2'b00};
    assign stall_o   = stall_c;

    // Next-state, handshake and MEM/WB capture; stalled cycles push a bubble into WB
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_c    = 1'b0;
        stall_c  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        trap     = 1'b0;
        pass     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    pass = 1'b1;
                end else if (misalign) begin
                    trap = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    req_c    = 1'b1;
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        pc_d   = pc_q;
        rd_d   = rd_q;
        wbd_d  = wbd_q;
        wbe_d  = 1'b0;
        berr_d = 1'b0;
        if (pass | complete | timeout | trap) begin
            pc_d   = pc_mem;
            rd_d   = rd_i;
            wbd_d  = (complete & is_load) ? ld_dat : aluOut_i;
            wbe_d  = (pass | complete) & registerWriteEnable_i & ~dataWriteEnable_i;
            berr_d = timeout | trap;
        end
    end

    // State, wait counter and MEM/WB registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            wbe_q   <= 1'b0;
            wbd_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wbe_q   <= wbe_d;
            wbd_q   <= wbd_d;
            berr_q  <= berr_d;
        end
    end

    assign pc_wb                 = pc_q;
    assign rd_o                  = rd_q;
    assign registerWriteEnable_o = wbe_q;
    assign wbData_o              = wbd_q;
    assign busError_o            = berr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: ALU pass, loads/stores with waits, timeout, reset, misalign.
// Latency: checks registered results 1 cycle after completion.
// Backpressure: counts stall_o cycles against hand-computed wait counts.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_mem;
    logic        registerWriteEnable_i, dataWriteEnable_i, regSelect_i;
    logic [2:0]  memSize_i;
    logic [31:0] aluOut_i, dataB_i;
    logic [4:0]  rd_i;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_o;
    logic [31:0] pc_wb;
    logic        registerWriteEnable_o;
    logic [4:0]  rd_o;
    logic [31:0] wbData_o;
    logic        busError_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int stalls;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .pc_mem(pc_mem),
        .registerWriteEnable_i(registerWriteEnable_i), .dataWriteEnable_i(dataWriteEnable_i),
        .regSelect_i(regSelect_i), .memSize_i(memSize_i), .aluOut_i(aluOut_i),
        .dataB_i(dataB_i), .rd_i(rd_i), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_o(stall_o), .pc_wb(pc_wb),
        .registerWriteEnable_o(registerWriteEnable_o), .rd_o(rd_o), .wbData_o(wbData_o),
        .busError_o(busError_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_nop();
        registerWriteEnable_i = 1'b0; dataWriteEnable_i = 1'b0; regSelect_i = 1'b0;
        memSize_i = 3'b010; rd_i = 5'd0; dmem_ack = 1'b0;
    endtask

    // Drives one instruction at a negedge and runs the ack handshake; returns in the
    // completing (stall_o low) cycle, #1 after the negedge, before the capturing edge.
    task automatic do_op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] bdat,
                         input logic [2:0] sz, input logic ld, input logic st, input logic we,
                         input logic [4:0] rd, input int ack_after, input logic [31:0] rdat,
                         output int nstall);
        bit done;
        @(negedge clk);
        pc_mem = pc; aluOut_i = addr; dataB_i = bdat; memSize_i = sz;
        regSelect_i = ld; dataWriteEnable_i = st; registerWriteEnable_i = we; rd_i = rd;
        dmem_rdata = rdat; dmem_ack = (ack_after == 0);
        nstall = 0;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall_o) begin
                done = 1'b1;
                break;
            end
            nstall++;
            @(negedge clk);
            if (nstall == ack_after) dmem_ack = 1'b1;
        end
        if (!done) chk("stall_bound", 32'd1, 32'd0);
    endtask

    task automatic wb_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pc_mem = 32'h0; aluOut_i = 32'h0; dataB_i = 32'h0; dmem_rdata = 32'h0;
        drive_nop();
        regSelect_i = 1'b1;  // a pending load must not leak a request during reset
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_pc", pc_wb, 32'd0);
        chk("rst_rd", {27'b0, rd_o}, 32'd0);
        chk("rst_wbd", wbData_o, 32'd0);
        chk("rst_wbe", {31'b0, registerWriteEnable_o}, 32'd0);
        chk("rst_berr", {31'b0, busError_o}, 32'd0);
        @(negedge clk);
        drive_nop();
        rst = 1'b0;

        // ALU pass-through
        do_op(32'h40, 32'h1234_5678, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 5'd5, 0, 32'h0, stalls);
        chk("alu_stalls", stalls, 0);
        chk("alu_req", {31'b0, dmem_req}, 32'd0);
        wb_edge();
        chk("alu_wbd", wbData_o, 32'h1234_5678);
        chk("alu_rd", {27'b0, rd_o}, 32'd5);
        chk("alu_wbe", {31'b0, registerWriteEnable_o}, 32'd1);
        chk("alu_pc", pc_wb, 32'h40);

        // LB with two wait states
        do_op(32'h44, 32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7, 2, 32'h80FF_0000, stalls);
        chk("lb_stalls", stalls, 2);
        chk("lb_req", {31'b0, dmem_req}, 32'd1);
        chk("lb_be", {28'b0, dmem_be}, 32'h8);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", {31'b0, dmem_we}, 32'd0);
        wb_edge();
        chk("lb_wbd", wbData_o, 32'hFFFF_FF80);
        chk("lb_rd", {27'b0, rd_o}, 32'd7);
        chk("lb_wbe", {31'b0, registerWriteEnable_o}, 32'd1);
        drive_nop();

        // Same access as LBU
        do_op(32'h48, 32'h103, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd8, 2, 32'h80FF_0000, stalls);
        chk("lbu_stalls", stalls, 2);
        wb_edge();
        chk("lbu_wbd", wbData_o, 32'h0000_0080);
        drive_nop();

        // LH / LHU upper half, LH lower half
        do_op(32'h4C, 32'h102, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd9, 0, 32'h8001_7FFF, stalls);
        chk("lh_be", {28'b0, dmem_be}, 32'hC);
        wb_edge();
        chk("lh_wbd", wbData_o, 32'hFFFF_8001);
        do_op(32'h50, 32'h102, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd9, 0, 32'h8001_7FFF, stalls);
        wb_edge();
        chk("lhu_wbd", wbData_o, 32'h0000_8001);
        do_op(32'h54, 32'h100, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd9, 0, 32'h8001_7FFF, stalls);
        wb_edge();
        chk("lh_lo_wbd", wbData_o, 32'h0000_7FFF);
        drive_nop();

        // SH zero-wait
        do_op(32'h58, 32'h202, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 1'b1, 5'd3, 0, 32'h0, stalls);
        chk("sh_stalls", stalls, 0);
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'b0, dmem_we}, 32'd1);
        wb_edge();
        chk("sh_wbe", {31'b0, registerWriteEnable_o}, 32'd0);
        drive_nop();

        // SB with one wait, SW zero-wait
        do_op(32'h5C, 32'h301, 32'h1234_565A, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 1, 32'h0, stalls);
        chk("sb_stalls", stalls, 1);
        chk("sb_be", {28'b0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        wb_edge();
        drive_nop();
        do_op(32'h60, 32'h300, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 1'b1, 5'd4, 0, 32'h0, stalls);
        chk("sw_be", {28'b0, dmem_be}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        wb_edge();
        drive_nop();

        // Stray ack with no request is ignored
        do_op(32'h64, 32'h0000_0777, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 5'd6, 0, 32'h0, stalls);
        chk("stray_req", {31'b0, dmem_req}, 32'd0);
        chk("stray_stall", {31'b0, stall_o}, 32'd0);
        wb_edge();
        chk("stray_wbd", wbData_o, 32'h0000_0777);
        drive_nop();

        // Timeout: ack never comes
        do_op(32'h68, 32'h400, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd10, 1000, 32'h0, stalls);
        chk("to_stalls", stalls, 15);
        wb_edge();
        chk("to_berr", {31'b0, busError_o}, 32'd1);
        chk("to_wbe", {31'b0, registerWriteEnable_o}, 32'd0);
        chk("to_pc", pc_wb, 32'h68);
        drive_nop();
        wb_edge();
        chk("to_berr_clr", {31'b0, busError_o}, 32'd0);

        // Reset mid-WAIT, then a normal load
        @(negedge clk);
        pc_mem = 32'h70; aluOut_i = 32'h200; memSize_i = 3'b010;
        regSelect_i = 1'b1; registerWriteEnable_i = 1'b1; rd_i = 5'd11; dmem_ack = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("mid_req", {31'b0, dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
        chk("mid_rst_wbd", wbData_o, 32'd0);
        chk("mid_rst_pc", pc_wb, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h74, 32'h200, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd12, 1, 32'hDEAD_BEEF, stalls);
        chk("post_rst_stalls", stalls, 1);
        wb_edge();
        chk("post_rst_wbd", wbData_o, 32'hDEAD_BEEF);
        chk("post_rst_rd", {27'b0, rd_o}, 32'd12);
        drive_nop();

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        do_op(32'h78, 32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd13, 0, 32'h1122_3344, stalls);
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_stalls", stalls, 0);
        wb_edge();
        chk("mis_berr", {31'b0, busError_o}, 32'd1);
        chk("mis_wbe", {31'b0, registerWriteEnable_o}, 32'd0);
        chk("mis_wbd", wbData_o, 32'h101);
`else
        do_op(32'h78, 32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd13, 0, 32'h1122_3344, stalls);
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_be", {28'b0, dmem_be}, 32'hF);
        wb_edge();
        chk("mis_wbd", wbData_o, 32'h1122_3344);
        chk("mis_berr", {31'b0, busError_o}, 32'd0);
`endif
        drive_nop();
        wb_edge();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
